regfile_lq: RTL

Parametrised register file for the datapath, replacing the fixed 8-entry, two-read-port file. It has an asynchronous active-low reset, write-first bypass on both read ports and an in-order load-writeback queue. A per-register pending scoreboard raises hazard flags toward pipeline control when a read targets a register still awaiting load data. It sits between decode (read addresses), execute (ALU writeback) and the memory interface (load data return).

---
 rtl/regfile_lq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/regfile_lq.sv
// regfile_lq: parametrised register file with write-first read bypass and an
// in-order load-writeback queue. A per-register pending bit marks registers
// still waiting for load data; reads of such registers raise o_hazardX.
//
// Ports:
//   i_clk, i_reset_n            clock (rising edge), async active-low reset
//   i_regwrite/i_RegD_addr/
//   i_ALUout                    ALU writeback
//   i_load_valid/i_load_addr    load issue; o_load_ready = queue not full
//   i_mem_valid/i_Memdata       load data return, in issue order
//   i_RegA_addr/i_RegB_addr     read addresses
//   o_RegA/o_RegB               registered read data (post-write view)
//   o_hazardA/o_hazardB         registered pending flag of the read register
//   o_resp_err                  pulse: load return with an empty queue
module regfile_lq #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 5,
  parameter int LQ_DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_regwrite,
  input  logic [ADDR_W-1:0] i_RegD_addr,
  input  logic [WIDTH-1:0]  i_ALUout,
  input  logic              i_load_valid,
  input  logic [ADDR_W-1:0] i_load_addr,
  output logic              o_load_ready,
  input  logic              i_mem_valid,
  input  logic [WIDTH-1:0]  i_Memdata,
  input  logic [ADDR_W-1:0] i_RegA_addr,
  input  logic [ADDR_W-1:0] i_RegB_addr,
  output logic [WIDTH-1:0]  o_RegA,
  output logic [WIDTH-1:0]  o_RegB,
  output logic              o_hazardA,
  output logic              o_hazardB,
  output logic              o_resp_err
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(LQ_DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0]    r_table, w_tbl_nxt;
  logic [DEPTH-1:0]               r_pend, w_pend_nxt;
  logic [LQ_DEPTH-1:0][IDX_W-1:0] r_fifo;
  logic [PTR_W-1:0]               r_wptr, r_rptr;
  logic [CNT_W-1:0]               r_count;
  logic [WIDTH-1:0]               r_RegA, r_RegB;
  logic                           r_hazA, r_hazB, r_err;

  logic [IDX_W-1:0] w_d_idx, w_ld_idx, w_a_idx, w_b_idx, w_pop_idx;
  logic             w_push, w_pop, w_keep;

  // Upper address bits are intentionally ignored (aliasing).
  logic w_unused;
  assign w_unused = &{1'b0, i_RegD_addr, i_load_addr, i_RegA_addr, i_RegB_addr};

  assign w_d_idx   = i_RegD_addr[IDX_W-1:0];
  assign w_ld_idx  = i_load_addr[IDX_W-1:0];
  assign w_a_idx   = i_RegA_addr[IDX_W-1:0];
  assign w_b_idx   = i_RegB_addr[IDX_W-1:0];
  assign w_pop_idx = r_fifo[r_rptr];

  // Readiness depends only on registered count, so a same-cycle pop can't
  // make room for an issue.
  assign o_load_ready = (r_count < CNT_W'(LQ_DEPTH));
  assign w_push       = i_load_valid && o_load_ready;
  assign w_pop        = i_mem_valid && (r_count != '0);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pending survives a pop when a younger queued entry (not the head) or a
  // same-cycle accepted issue targets the same register.
  always_comb begin
    w_keep = 1'b0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      int off;
      off = (i >= int'(r_rptr)) ? i - int'(r_rptr) : i + LQ_DEPTH - int'(r_rptr);
      if (off != 0 && off < int'(r_count) && r_fifo[i] == w_pop_idx) w_keep = 1'b1;
    end
    if (w_push && w_ld_idx == w_pop_idx) w_keep = 1'b1;
  end

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_pop && !w_keep) w_pend_nxt[w_pop_idx] = 1'b0;
    if (w_push)           w_pend_nxt[w_ld_idx]  = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  // Load data first, ALU second: the ALU op is younger and wins on collision.
  always_comb begin
    w_tbl_nxt = r_table;
    if (w_pop)      w_tbl_nxt[w_pop_idx] = i_Memdata;
    if (i_regwrite) w_tbl_nxt[w_d_idx]   = i_ALUout;
    w_tbl_nxt[0] = '0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_table <= '0;
      r_pend  <= '0;
      r_fifo  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_RegA  <= '0;
      r_RegB  <= '0;
      r_hazA  <= 1'b0;
      r_hazB  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_table <= w_tbl_nxt;
      r_pend  <= w_pend_nxt;
      if (w_push) begin
        r_fifo[r_wptr] <= w_ld_idx;
        r_wptr         <= ptr_inc(r_wptr);
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_RegA <= w_tbl_nxt[w_a_idx];
      r_RegB <= w_tbl_nxt[w_b_idx];
      r_hazA <= w_pend_nxt[w_a_idx];
      r_hazB <= w_pend_nxt[w_b_idx];
      r_err  <= i_mem_valid && (r_count == '0);
    end
  end

  assign o_RegA     = r_RegA;
  assign o_RegB     = r_RegB;
  assign o_hazardA  = r_hazA;
  assign o_hazardB  = r_hazB;
  assign o_resp_err = r_err;
endmodule
